// File: rtl/mcp_rx_buf.sv
// Receive-side buffer behind mcp_blk: acknowledges each bvalid word with bload, stores it in a
// first-word-fall-through FIFO, and keeps a word count and modular checksum for link monitoring.
module mcp_rx_buf #(
  parameter int unsigned DW    = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     bclk,
  input  logic                     brst,
  input  logic                     sclr,
  input  logic                     bvalid,
  input  logic [DW-1:0]            bdata,
  output logic                     bload,
  output logic [DW-1:0]            dout,
  output logic                     dvalid,
  input  logic                     dready,
  output logic [$clog2(DEPTH):0]   level,
  output logic [15:0]              byte_cnt,
  output logic [DW-1:0]            csum
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam logic [LW-1:0] LevelFull = LW'(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [LW-1:0] level_q;
  logic [15:0]   byte_cnt_q;
  logic [DW-1:0] csum_q;

  logic full;
  logic push;
  logic pop;

  assign full   = (level_q == LevelFull);
  assign dvalid = (level_q != '0);

  // brst is in the bload term so the acknowledge drops the instant reset asserts.
  assign bload  = bvalid && !full && !sclr && !brst;
  assign push   = bload;
  assign pop    = dvalid && dready && !sclr;

  assign dout     = mem_q[rd_ptr_q];
  assign level    = level_q;
  assign byte_cnt = byte_cnt_q;
  assign csum     = csum_q;

  always_ff @(posedge bclk or posedge brst) begin
    if (brst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      byte_cnt_q <= '0;
      csum_q     <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (sclr) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      byte_cnt_q <= '0;
      csum_q     <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= bdata;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
        byte_cnt_q      <= byte_cnt_q + 16'd1;
        csum_q          <= csum_q + bdata;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

endmodule

// File: tb/tb_mcp_rx_buf.sv
// Self-checking bench for mcp_rx_buf: a queue-based reference FIFO checks every edge, while
// directed sequences exercise fill/full, wrap, push+pop, sclr and async reset.
module tb_mcp_rx_buf;

  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 4;

  logic          bclk;
  logic          brst;
  logic          sclr;
  logic          bvalid;
  logic [DW-1:0] bdata;
  logic          bload;
  logic [DW-1:0] dout;
  logic          dvalid;
  logic          dready;
  logic [2:0]    level;
  logic [15:0]   byte_cnt;
  logic [DW-1:0] csum;

  int n_cmp = 0;
  int n_err = 0;
  bit cons_rand = 0;

  // Reference model: contents in arrival order plus running count and sum.
  logic [DW-1:0] mq[$];
  int unsigned   m_cnt;
  int unsigned   m_sum;

  mcp_rx_buf #(.DW(DW), .DEPTH(DEPTH)) dut (
    .bclk     (bclk),
    .brst     (brst),
    .sclr     (sclr),
    .bvalid   (bvalid),
    .bdata    (bdata),
    .bload    (bload),
    .dout     (dout),
    .dvalid   (dvalid),
    .dready   (dready),
    .level    (level),
    .byte_cnt (byte_cnt),
    .csum     (csum)
  );

  initial begin
    bclk = 1'b0;
    forever #5 bclk = ~bclk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor/scoreboard: inputs change only just after posedge, so the negedge view is
  // exactly what the next rising edge will act on.
  always @(negedge bclk) begin
    if (brst) begin
      chk("rst_bload", 32'(bload), 32'd0);
      chk("rst_dvalid", 32'(dvalid), 32'd0);
      chk("rst_dout", 32'(dout), 32'd0);
      chk("rst_level", 32'(level), 32'd0);
      chk("rst_byte_cnt", 32'(byte_cnt), 32'd0);
      chk("rst_csum", 32'(csum), 32'd0);
      mq.delete();
      m_cnt = 0;
      m_sum = 0;
    end else begin
      automatic bit exp_load = bvalid && (mq.size() < DEPTH) && !sclr;
      chk("bload", 32'(bload), 32'(exp_load));
      chk("dvalid", 32'(dvalid), 32'(mq.size() != 0));
      chk("level", 32'(level), 32'(mq.size()));
      chk("byte_cnt", 32'(byte_cnt), m_cnt % 65536);
      chk("csum", 32'(csum), m_sum % 256);
      if (sclr) begin
        mq.delete();
        m_cnt = 0;
        m_sum = 0;
      end else begin
        if (mq.size() != 0 && dready) begin
          chk("pop_data", 32'(dout), 32'(mq[0]));
          void'(mq.pop_front());
        end
        if (exp_load) begin
          mq.push_back(bdata);
          m_cnt++;
          m_sum += bdata;
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge bclk);
      #1;
      if (cons_rand) dready = 1'($urandom_range(0, 1));
    end
  end

  // Emulates mcp_blk: bvalid is low for at least one cycle between words and drops right
  // after the edge that loaded the word.
  task automatic push_word(input logic [DW-1:0] d);
    bit done = 0;
    @(posedge bclk);
    #1;
    bvalid = 1'b1;
    bdata  = d;
    for (int n = 0; n < 200; n++) begin
      @(negedge bclk);
      if (bload) begin
        done = 1;
        break;
      end
    end
    if (!done) begin
      n_cmp++;
      n_err++;
      $display("FAIL push_timeout: got no bload expected bload for 0x%0h", d);
    end
    @(posedge bclk);
    #1;
    bvalid = 1'b0;
    bdata  = DW'($urandom);
  endtask

  task automatic pulse_sclr();
    @(posedge bclk);
    #1 sclr = 1'b1;
    @(posedge bclk);
    #1 sclr = 1'b0;
  endtask

  task automatic wait_empty();
    bit done = 0;
    for (int n = 0; n < 300; n++) begin
      @(negedge bclk);
      if (level == 0) begin
        done = 1;
        break;
      end
    end
    if (!done) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain_timeout: got level %0d expected 0", level);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] s;
    brst = 1'b1;
    sclr = 1'b0;
    bvalid = 1'b0;
    bdata = '0;
    dready = 1'b0;
    repeat (3) @(posedge bclk);
    #1 brst = 1'b0;

    // Single word after reset.
    push_word(8'hA5);
    @(negedge bclk);
    chk("t1_dvalid", 32'(dvalid), 32'd1);
    chk("t1_dout", 32'(dout), 32'hA5);
    chk("t1_level", 32'(level), 32'd1);
    chk("t1_byte_cnt", 32'(byte_cnt), 32'd1);
    chk("t1_csum", 32'(csum), 32'hA5);
    @(posedge bclk);
    #1 dready = 1'b1;
    wait_empty();
    @(posedge bclk);
    #1 dready = 1'b0;

    // Fill to full, then free one slot.
    pulse_sclr();
    for (int i = 1; i <= 4; i++) push_word(DW'(i));
    @(posedge bclk);
    #1;
    bvalid = 1'b1;
    bdata  = 8'h05;
    repeat (3) begin
      @(negedge bclk);
      chk("full_bload", 32'(bload), 32'd0);
    end
    chk("full_level", 32'(level), 32'd4);
    @(posedge bclk);
    #1 dready = 1'b1;
    @(negedge bclk);
    chk("full_no_passthru", 32'(bload), 32'd0);
    chk("full_head", 32'(dout), 32'h01);
    @(posedge bclk);
    #1 dready = 1'b0;
    @(negedge bclk);
    chk("full_refill_bload", 32'(bload), 32'd1);
    chk("full_after_pop", 32'(level), 32'd3);
    @(posedge bclk);
    #1 bvalid = 1'b0;
    @(negedge bclk);
    chk("full_refilled", 32'(level), 32'd4);
    @(posedge bclk);
    #1 dready = 1'b1;
    wait_empty();

    // Streaming with wrap; order is checked by the scoreboard.
    pulse_sclr();
    s = '0;
    for (int i = 0; i < 10; i++) begin
      push_word(DW'(8'h10 + i));
      s = s + DW'(8'h10 + i);
    end
    repeat (2) @(negedge bclk);
    chk("wrap_byte_cnt", 32'(byte_cnt), 32'd10);
    chk("wrap_csum", 32'(csum), 32'(s));
    chk("wrap_level", 32'(level), 32'd0);

    // Simultaneous push and pop at level 2.
    @(posedge bclk);
    #1 dready = 1'b0;
    pulse_sclr();
    push_word(8'h31);
    push_word(8'h32);
    @(posedge bclk);
    #1;
    bvalid = 1'b1;
    bdata  = 8'h33;
    dready = 1'b1;
    @(negedge bclk);
    chk("pp_bload", 32'(bload), 32'd1);
    chk("pp_head0", 32'(dout), 32'h31);
    @(posedge bclk);
    #1;
    bvalid = 1'b0;
    dready = 1'b0;
    @(negedge bclk);
    chk("pp_level", 32'(level), 32'd2);
    chk("pp_head1", 32'(dout), 32'h32);

    // sclr with a pending word.
    push_word(8'h34);
    @(posedge bclk);
    #1;
    bvalid = 1'b1;
    bdata  = 8'h44;
    sclr   = 1'b1;
    @(negedge bclk);
    chk("sclr_bload", 32'(bload), 32'd0);
    chk("sclr_pre_level", 32'(level), 32'd3);
    @(posedge bclk);
    #1 sclr = 1'b0;
    @(negedge bclk);
    chk("sclr_level", 32'(level), 32'd0);
    chk("sclr_byte_cnt", 32'(byte_cnt), 32'd0);
    chk("sclr_csum", 32'(csum), 32'd0);
    chk("sclr_late_bload", 32'(bload), 32'd1);
    @(posedge bclk);
    #1 bvalid = 1'b0;
    @(negedge bclk);
    chk("sclr_taken_level", 32'(level), 32'd1);
    chk("sclr_taken_dout", 32'(dout), 32'h44);

    // Random streaming, then async reset between edges with a word pending.
    cons_rand = 1;
    for (int i = 0; i < 12; i++) push_word(DW'($urandom));
    cons_rand = 0;
    @(posedge bclk);
    #1;
    dready = 1'b0;
    bvalid = 1'b1;
    bdata  = DW'($urandom);
    #2 brst = 1'b1;
    #1;
    chk("arst_bload_now", 32'(bload), 32'd0);
    chk("arst_dvalid_now", 32'(dvalid), 32'd0);
    bvalid = 1'b0;
    repeat (2) @(posedge bclk);
    #1 brst = 1'b0;

    cons_rand = 1;
    for (int i = 0; i < 30; i++) push_word(DW'($urandom));
    cons_rand = 0;
    @(posedge bclk);
    #1 dready = 1'b1;
    wait_empty();
    @(negedge bclk);
    chk("final_model_empty", 32'(mq.size()), 32'd0);
    chk("final_byte_cnt", 32'(byte_cnt), 32'd30);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
